// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake and result bus of the multiply/divide sequencer
interface muldiv_seq_if #(
    parameter int width = 32
);
    logic             start;
    logic [1:0]       op;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             busy;
    logic             done;
    logic [width-1:0] hi;
    logic [width-1:0] lo;
    logic             div_zero;

    modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: one-bit-per-cycle shift-add multiply / restoring divide; signed MULT/DIV only when MULDIV_SIGNED_EN is defined
module muldiv_seq #(
    parameter int width = 32
) (
    input  logic        clock,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int cw = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [width-1:0] a_q, a_d, b_q, b_d;
    logic [width-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mcand_q, mcand_d;
    logic [width-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d;
    logic [width-1:0] mag_a, mag_b, fix_hi, fix_lo;
    logic [2:0]       alu_op;
    logic [width:0]   alu_x, alu_y, alu_r, mul_sum;
    logic             alu_neg;
    logic             last;

    assign last = cnt_q == cw'(width - 1);

    // Shared (width+1)-bit ALU: ADD 3'b010, SUB 3'b011; negative is the top bit
    always_comb begin
        alu_r   = (alu_op == 3'b011) ? alu_x - alu_y : alu_x + alu_y;
        alu_neg = alu_r[width];
    end

    // ALU operands: multiply adds the multiplicand to the upper accumulator,
    // divide subtracts the divisor from the remainder after the left shift
    // (the shifted-out remainder bit is kept so large divisors stay exact)
    always_comb begin
        alu_op = div_q ? 3'b011 : 3'b010;
        alu_x  = div_q ? {acc_hi_q, acc_lo_q[width-1]} : {1'b0, acc_hi_q};
        alu_y  = {1'b0, mcand_q};
    end

`ifdef MULDIV_SIGNED_EN
    logic               sgn_q, sgn_d, neg_a, neg_b;
    logic [2*width-1:0] prod;

    // Signed-op select captured together with the operands
    always_comb sgn_d = (state_q == IDLE && bus.start) ? bus.op[1] : sgn_q;

    // Signed-op select register
    always_ff @(posedge clock) sgn_q <= reset ? 1'b0 : sgn_d;

    // Operand magnitudes for PREP; product/quotient/remainder sign restore for FIX
    always_comb begin
        neg_a  = sgn_q & a_q[width-1];
        neg_b  = sgn_q & b_q[width-1];
        mag_a  = neg_a ? -a_q : a_q;
        mag_b  = neg_b ? -b_q : b_q;
        prod   = (neg_a ^ neg_b) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        fix_hi = div_q ? (neg_a ? -acc_hi_q : acc_hi_q) : prod[2*width-1:width];
        fix_lo = div_q ? ((neg_a ^ neg_b) ? -acc_lo_q : acc_lo_q) : prod[width-1:0];
    end
`else
    // Unsigned-only build: PREP and FIX pass values straight through
    always_comb begin
        mag_a  = a_q;
        mag_b  = b_q;
        fix_hi = acc_hi_q;
        fix_lo = acc_lo_q;
    end
`endif

    // Next state and datapath updates for IDLE -> PREP -> ITER x width -> FIX -> DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        mul_sum  = acc_lo_q[0] ? alu_r : alu_x;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = PREP;
                    div_d   = bus.op[0];
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dz_d    = 1'b0;
                end
            end
            PREP: begin
                state_d  = ITER;
                acc_hi_d = '0;
                acc_lo_d = div_q ? mag_a : mag_b;
                mcand_d  = div_q ? mag_b : mag_a;
            end
            ITER: begin
                state_d  = last ? FIX : ITER;
                cnt_d    = last ? '0 : cnt_q + 1'b1;
                acc_hi_d = div_q ? (alu_neg ? alu_x[width-1:0] : alu_r[width-1:0]) : mul_sum[width:1];
                acc_lo_d = div_q ? {acc_lo_q[width-2:0], ~alu_neg} : {mul_sum[0], acc_lo_q[width-1:1]};
            end
            FIX: begin
                state_d = DONE;
                dz_d    = div_q && b_q == '0;
                hi_d    = (div_q && b_q == '0) ? a_q : fix_hi;
                lo_d    = (div_q && b_q == '0) ? '1 : fix_lo;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule
